// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised synchronous FIFO family.
// Error-flag bit positions are also used by the status register block.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 10;

    localparam int ERR_W       = 2;
    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;

    // One extra bit so the occupancy can represent a completely full FIFO.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_1w1r.sv
// Behavioural DATA_W x 2**ADDR_W memory with one write port and a registered read port.
// Behavioural equivalent of the sky130 1rw1r SRAM macro (8 x 1024), which can replace it.
module fifo_ram_1w1r #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-address read and write return the old word (read-before-write).
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with registered read data, occupancy count, almost flags
// and sticky overflow/underflow error flags.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = 1020,
    parameter int AE_LEVEL = 4
) (
    input  logic                        clk0,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_w(ADDR_W)-1:0]    count,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        clr_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = cnt_w(ADDR_W);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    if (ADDR_W < 2 || AE_LEVEL <= 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL >= DEPTH) begin : g_param_check
        $error("fifo_sync_param: illegal parameters (need ADDR_W>=2, 0<AE_LEVEL<AF_LEVEL<DEPTH)");
    end

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             rd_valid_q;
    logic [ERR_W-1:0] err_q, err_d;
    logic             wr_ok, rd_ok;

    // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok    = rd_en & ~empty_q;
        wr_ok    = wr_en & (~full_q | rd_ok);
        wr_ptr_d = wr_ptr_q + CNT_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + CNT_W'(rd_ok);
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_C);
        aempty_d = (count_d <= AE_C);

        err_d = err_q;
        if (clr_err) begin
            err_d = '0;
        end
        if (wr_en & ~wr_ok) begin
            err_d[ERR_OVF_BIT] = 1'b1;
        end
        if (rd_en & ~rd_ok) begin
            err_d[ERR_UDF_BIT] = 1'b1;
        end
    end

    always_ff @(posedge clk0) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            rd_valid_q <= rd_ok;
            err_q      <= err_d;
        end
    end

    fifo_ram_1w1r #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk0),
        .rst_n_i (reset_n),
        .we_i    (wr_ok & reset_n),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_ok),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = err_q[ERR_OVF_BIT];
    assign underflow    = err_q[ERR_UDF_BIT];

endmodule
